video_stream_sink: RTL and testbench

VIDEO_STREAM_SINK -- requirements
Module: video_stream_sink

---
 rtl/video_stream_sink.sv | 157 +++++++++++++++
 tb/tb_video_stream_sink.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/video_stream_sink.sv
// Video timing generator that drains a 4-pixel-per-beat stream through a 2-entry FIFO
// and emits registered RGB, data-enable and sync outputs.
module video_stream_sink #(
  parameter int H_FRONT  = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BACK   = 148,
  parameter int V_FRONT  = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 36,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] video_width,
  input  logic [15:0] video_height,
  output logic        start_frame,
  output logic        ready,
  input  logic        valid,
  input  logic [63:0] bits_0,
  input  logic [63:0] bits_1,
  input  logic [63:0] bits_2,
  input  logic [63:0] bits_3,
  output logic [23:0] pixel_data,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        underflow
);

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef logic [3:0][23:0] beat_t;

  state_t           state_q, state_d;
  logic [15:0]      h_q, h_d, v_q, v_d;
  logic [1:0][95:0] mem_q, mem_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             grp_uf_q, grp_uf_d, uf_q, uf_d;
  logic             sf_q, sf_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [23:0]      pix_q, pix_d;

  // Totals are kept 17 bits wide so large widths plus porches never wrap.
  logic [16:0] h17, v17, hs_lo, hs_hi, h_last, vs_lo, vs_hi, v_last;
  assign h17    = {1'b0, h_q};
  assign v17    = {1'b0, v_q};
  assign hs_lo  = {1'b0, video_width} + 17'(H_FRONT);
  assign hs_hi  = hs_lo + 17'(H_SYNC);
  assign h_last = hs_hi + 17'(H_BACK) - 17'd1;
  assign vs_lo  = {1'b0, video_height} + 17'(V_FRONT);
  assign vs_hi  = vs_lo + 17'(V_SYNC);
  assign v_last = vs_hi + 17'(V_BACK) - 17'd1;

  logic  run, active, empty, grp_start, uf_now, push, pop;
  beat_t head;

  assign run       = (state_q == S_RUN);
  assign active    = run && (h_q < video_width) && (v_q < video_height);
  assign empty     = (cnt_q == 2'd0);
  assign grp_start = active && (h_q[1:0] == 2'd0);
  // A group that started on an empty FIFO stays black for all four pixels.
  assign uf_now    = active && (grp_start ? empty : grp_uf_q);
  assign pop       = active && (h_q[1:0] == 2'd3) && !uf_now && !empty;
  assign ready     = run && (cnt_q != 2'd2);
  assign push      = valid && ready;
  assign head      = beat_t'(mem_q[rd_q]);

  logic unused_hi_bits;
  assign unused_hi_bits = ^{bits_0[63:24], bits_1[63:24], bits_2[63:24], bits_3[63:24]};

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (!run) begin
      state_d = S_RUN;
      h_d     = 16'd0;
      v_d     = video_height;
    end else if (h17 == h_last) begin
      h_d = 16'd0;
      v_d = (v17 == v_last) ? 16'd0 : v_q + 16'd1;
    end else begin
      h_d = h_q + 16'd1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    // The start_frame cycle drops everything, including a beat handshaked right then.
    if (sf_q) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_q] = {bits_3[23:0], bits_2[23:0], bits_1[23:0], bits_0[23:0]};
        wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    grp_uf_d = grp_start ? empty : grp_uf_q;
    uf_d     = uf_q | uf_now;
    sf_d     = run && (h_q == 16'd0) && (v_q == video_height);
    de_d     = active;
    pix_d    = (active && !uf_now) ? head[h_q[1:0]] : 24'h000000;
    hs_d     = (h17 >= hs_lo && h17 < hs_hi) ? SYNC_POL : ~SYNC_POL;
    vs_d     = (v17 >= vs_lo && v17 < vs_hi) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_INIT;
      h_q      <= '0;
      v_q      <= '0;
      mem_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      grp_uf_q <= 1'b0;
      uf_q     <= 1'b0;
      sf_q     <= 1'b0;
      de_q     <= 1'b0;
      pix_q    <= '0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      mem_q    <= mem_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      grp_uf_q <= grp_uf_d;
      uf_q     <= uf_d;
      sf_q     <= sf_d;
      de_q     <= de_d;
      pix_q    <= pix_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign start_frame = sf_q;
  assign pixel_data  = pix_q;
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_video_stream_sink.sv
// Scoreboard bench: a stream model predicts pixels, ready and underflow; a monitor checks outputs.
module tb_video_stream_sink;
  localparam int W = 8, HG = 2, HT = 14, VT = 5, FT = HT * VT;

  logic        clock = 1'b0, reset = 1'b1, valid = 1'b0;
  logic [15:0] video_width = 16'd8, video_height = 16'd2;
  logic [63:0] bits_0 = '0, bits_1 = '0, bits_2 = '0, bits_3 = '0;
  logic        start_frame, ready, de, hsync, vsync, underflow;
  logic [23:0] pixel_data;

  video_stream_sink #(.H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_FRONT(1), .V_SYNC(1),
                      .V_BACK(1), .SYNC_POL(1'b1)) dut (
    .clock(clock), .reset(reset), .video_width(video_width), .video_height(video_height),
    .start_frame(start_frame), .ready(ready), .valid(valid),
    .bits_0(bits_0), .bits_1(bits_1), .bits_2(bits_2), .bits_3(bits_3),
    .pixel_data(pixel_data), .de(de), .hsync(hsync), .vsync(vsync), .underflow(underflow));

  always #5 clock = ~clock;

  int          n_cmp = 0, n_bad = 0, cyc = 0, epoch = 0, uf_cyc = 1 << 30;
  bit          sim_on = 1'b0;
  logic [23:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d epoch=%0d got=%0h want=%0h", name, cyc, epoch, act, exp);
    end
  endtask

  // Raster position during cycle c (c>=1): the first RUN cycle sits at h=0, v=height.
  function automatic int pos(input int c);
    return (c - 1 + HG * HT) % FT;
  endfunction
  function automatic int hpos(input int c);
    return pos(c) % HT;
  endfunction
  function automatic int vpos(input int c);
    return pos(c) / HT;
  endfunction
  function automatic bit act_at(input int c);
    return (hpos(c) < W) && (vpos(c) < HG);
  endfunction

  always @(posedge clock) cyc = reset ? 0 : cyc + 1;

  // Source plus stream model: accepted beats queue up, a group takes one beat or goes black.
  initial begin : stim
    logic [95:0] mq[$];
    logic [95:0] cur, beat;
    bit          hold, rdy_m, sf_now, v_now, seq;
    int          nacc, tag, c, f;
    hold = 0; nacc = 0; tag = 0;
    forever begin
      @(posedge clock); #2;
      if (reset || !sim_on) begin
        mq.delete(); expq.delete();
        hold = 0; nacc = 0; tag = 0; uf_cyc = 1 << 30; valid = 1'b0;
      end else begin
        c = cyc;
        rdy_m = (mq.size() + int'(hold)) < 2;
        chk("ready", ready, rdy_m);
        sf_now = (c >= 2) && ((c - 2) % FT == 0);
        if (sf_now) tag++;
        if (act_at(c) && hpos(c) % 4 == 0) begin
          if (mq.size() > 0) begin
            cur = mq.pop_front();
            hold = 1;
            for (int k = 0; k < 4; k++) expq.push_back(cur[24*k +: 24]);
          end else begin
            for (int k = 0; k < 4; k++) expq.push_back(24'h0);
            if (uf_cyc > c + 1) uf_cyc = c + 1;
          end
        end
        f = (c < 2) ? 0 : (c - 2) / FT;
        if (epoch != 0 || f <= 1) begin seq = 1; v_now = 1; end
        else if (f == 2) begin seq = 1; v_now = (vpos(c) >= HG); end
        else begin seq = 0; v_now = ($urandom_range(0, 99) < 55); end
        if (seq) begin
          for (int k = 0; k < 4; k++)
            beat[24*k +: 24] = {tag[7:0], 16'((nacc % 2) * 4 + k + 1)};
        end else begin
          beat = {$urandom, $urandom, $urandom};
        end
        bits_0 = {$urandom, 8'($urandom), beat[23:0]};
        bits_1 = {$urandom, 8'($urandom), beat[47:24]};
        bits_2 = {$urandom, 8'($urandom), beat[71:48]};
        bits_3 = {$urandom, 8'($urandom), beat[95:72]};
        valid  = v_now;
        if (sf_now) begin
          mq.delete();
          nacc = 0;
          hold = 0;
        end else if (v_now && rdy_m) begin
          mq.push_back(beat);
          nacc++;
        end
        if (act_at(c) && hpos(c) % 4 == 3) hold = 0;
      end
    end
  end

  // Monitor: outputs in cycle c come from the raster position of cycle c-1.
  initial begin : mon
    int          c, hp, vp;
    bit          ede;
    logic [23:0] ep;
    forever begin
      @(negedge clock);
      if (!reset && sim_on) begin
        c = cyc;
        if (c < 2) begin
          if (c == 0) chk("ready_init", ready, 1'b0);
          chk("de_idle", de, 1'b0);
          chk("hsync_idle", hsync, 1'b0);
          chk("vsync_idle", vsync, 1'b0);
          chk("start_idle", start_frame, 1'b0);
          chk("pixel_idle", pixel_data, 24'h0);
        end else begin
          hp  = hpos(c - 1);
          vp  = vpos(c - 1);
          ede = act_at(c - 1);
          chk("de", de, ede);
          chk("hsync", hsync, (hp >= W + 2) && (hp < W + 4));
          chk("vsync", vsync, vp == HG + 1);
          chk("start_frame", start_frame, (c - 2) % FT == 0);
          if (ede) begin
            if (expq.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL pixel_queue cyc=%0d got=%0h want=queued_pixel", c, pixel_data);
            end else begin
              ep = expq.pop_front();
              chk("pixel", pixel_data, ep);
            end
          end else begin
            chk("pixel_blank", pixel_data, 24'h0);
          end
        end
        chk("underflow", underflow, c >= uf_cyc);
      end
    end
  end

  task automatic chk_reset_outs(input string tag_s);
    chk({tag_s, "_ready"}, ready, 1'b0);
    chk({tag_s, "_start"}, start_frame, 1'b0);
    chk({tag_s, "_de"}, de, 1'b0);
    chk({tag_s, "_pixel"}, pixel_data, 24'h0);
    chk({tag_s, "_hsync"}, hsync, 1'b0);
    chk({tag_s, "_vsync"}, vsync, 1'b0);
    chk({tag_s, "_underflow"}, underflow, 1'b0);
  endtask

  initial begin
    sim_on = 1'b1;
    repeat (3) @(negedge clock);
    chk_reset_outs("rst");
    @(posedge clock); #3 reset = 1'b0;
    // Cycle 397 sits at h=4, v=0 of a random-traffic frame, mid active line.
    repeat (397) @(posedge clock);
    #3;
    chk("pre_reset_de", de, 1'b1);
    chk("pre_reset_underflow", underflow, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset_outs("async_rst");
    epoch = 1;
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    repeat (150) @(posedge clock);
    @(negedge clock);
    sim_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
